aes_word_io: RTL and testbench

Word-serial front/back end for the AES-128 core. It collects a 128-bit key and a 128-bit plaintext block from a 32-bit valid/ready input stream and drives them onto the core's `state`/`key` inputs. It waits the core's fixed latency, captures the core's `out`, and returns the ciphertext as four 32-bit words on a valid/ready output stream. It sits directly upstream and downstream of the `aes_128` core inside the top level.

---
 rtl/aes_io_pkg.sv | 21 ++
 rtl/aes_word_io_if.sv | 29 ++
 rtl/aes_word_io_word_packer.sv | 41 ++++
 rtl/aes_word_io.sv | 188 ++++++++++++++++++
 tb/tb_aes_word_io.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_io_pkg.sv
// Shared types and constants for the AES-128 word-serial I/O block.
// Contents:
//   fsm_state_t     - LOAD / RUN / DRAIN control states
//   WORDS_PER_BLOCK - 32-bit words per 128-bit block
//   WORD_W, BLOCK_W - stream word width and block width
//   LAST_IDX        - index of the final word in a block (2-bit counters)
package aes_io_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

  localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/aes_word_io_if.sv
// Word-stream bundle between a producer/consumer and aes_word_io.
// Signals:
//   in_valid / in_ready / in_data / in_sel : input word stream (in_sel 1 = key word)
//   out_valid / out_ready / out_data       : ciphertext word stream
// Modports:
//   master - the environment side (drives input words, accepts output words)
//   slave  - the aes_word_io side
interface aes_word_io_if;
  import aes_io_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_sel;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_word_io_word_packer.sv
// 32-to-128 bit word packer, most significant word first.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : accept one word this cycle
//   data     : incoming word
//   commit   : high in the cycle the 4th word of a block is accepted
//   word     : assembled block (three shadowed words plus the incoming one),
//              meaningful while commit is high
module word_packer
  import aes_io_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WORD_W-1:0]  data,
  output logic               commit,
  output logic [BLOCK_W-1:0] word
);

  // Only the first three words need storage; the fourth is used straight from data.
  logic [BLOCK_W-WORD_W-1:0] shadow_r;
  logic [1:0]                cnt_r;

  // Shift accepted words into the shadow and count them (wraps 3 -> 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= '0;
      cnt_r    <= 2'd0;
    end else if (en) begin
      shadow_r <= {shadow_r[BLOCK_W-2*WORD_W-1:0], data};
      cnt_r    <= cnt_r + 2'd1;
    end else begin
      shadow_r <= shadow_r;
      cnt_r    <= cnt_r;
    end
  end

  assign commit = en & (cnt_r == LAST_IDX);
  assign word   = {shadow_r, data};

endmodule

// File: rtl/aes_word_io.sv
// Word-serial front/back end for the AES-128 core.
// Collects a key and a plaintext block from a 32-bit stream, presents them to
// the core, waits LATENCY cycles, captures the core output and returns the
// ciphertext as four 32-bit words, most significant first.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   io        : word streams (slave side of aes_word_io_if)
//   busy      : a block is in flight (RUN or DRAIN)
//   aes_state : plaintext block to the core
//   aes_key   : last fully committed key to the core
//   aes_out   : ciphertext from the core
module aes_word_io
  import aes_io_pkg::*;
#(
  parameter int LATENCY = 21
) (
  input  logic               clk,
  input  logic               rst,
  aes_word_io_if.slave       io,
  output logic               busy,
  output logic [BLOCK_W-1:0] aes_state,
  output logic [BLOCK_W-1:0] aes_key,
  input  logic [BLOCK_W-1:0] aes_out
);

  localparam int               CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  fsm_state_t         state_r;
  fsm_state_t         next_state_s;
  logic               in_ready_s;
  logic               out_valid_nxt_s;
  logic               busy_nxt_s;
  logic               in_hs_s;
  logic               key_en_s;
  logic               pt_en_s;
  logic               key_commit_s;
  logic               pt_commit_s;
  logic [BLOCK_W-1:0] key_word_s;
  logic [BLOCK_W-1:0] pt_word_s;
  logic               lat_done_s;
  logic               out_hs_s;
  logic               drain_done_s;

  logic [CNT_W-1:0]   lat_cnt_r;
  logic [1:0]         out_idx_r;
  logic [BLOCK_W-1:0] result_r;
  logic [BLOCK_W-1:0] aes_state_r;
  logic [BLOCK_W-1:0] aes_key_r;
  logic               out_valid_r;
  logic               busy_r;

  assign in_hs_s      = io.in_valid & in_ready_s;
  assign key_en_s     = in_hs_s & io.in_sel;
  assign pt_en_s      = in_hs_s & ~io.in_sel;
  // The capture edge is the one on which the counter would step to LATENCY.
  assign lat_done_s   = (state_r == RUN) && (lat_cnt_r == LAST_CNT);
  assign out_hs_s     = out_valid_r & io.out_ready;
  assign drain_done_s = out_hs_s && (out_idx_r == LAST_IDX);

  word_packer u_key_packer (
    .clk    (clk),
    .rst    (rst),
    .en     (key_en_s),
    .data   (io.in_data),
    .commit (key_commit_s),
    .word   (key_word_s)
  );

  word_packer u_pt_packer (
    .clk    (clk),
    .rst    (rst),
    .en     (pt_en_s),
    .data   (io.in_data),
    .commit (pt_commit_s),
    .word   (pt_word_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= LOAD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LOAD: begin
        if (pt_commit_s) begin
          next_state_s = RUN;
        end else begin
          next_state_s = LOAD;
        end
      end
      RUN: begin
        if (lat_done_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = RUN;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = LOAD;
    endcase
  end

  // FSM outputs: in_ready from the current state, next values of the registered flags.
  always_comb begin
    in_ready_s      = 1'b0;
    out_valid_nxt_s = 1'b0;
    busy_nxt_s      = 1'b0;
    case (state_r)
      LOAD:    in_ready_s = 1'b1;
      RUN:     in_ready_s = 1'b0;
      DRAIN:   in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
    case (next_state_s)
      LOAD: begin
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
      end
      RUN: begin
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b1;
      end
      DRAIN: begin
        out_valid_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
      end
      default: begin
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
      end
    endcase
  end

  // Core operands, latency counter, result shifter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_key_r   <= '0;
      aes_state_r <= '0;
      lat_cnt_r   <= '0;
      result_r    <= '0;
      out_idx_r   <= 2'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (key_commit_s) begin
        aes_key_r <= key_word_s;
      end
      if (pt_commit_s) begin
        aes_state_r <= pt_word_s;
        lat_cnt_r   <= '0;
      end else if (state_r == RUN) begin
        lat_cnt_r <= lat_cnt_r + CNT_W'(1);
      end
      // out_data is the top word of result_r, so each accepted word shifts the next one up.
      if (lat_done_s) begin
        result_r  <= aes_out;
        out_idx_r <= 2'd0;
      end else if (out_hs_s) begin
        result_r  <= {result_r[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
        out_idx_r <= out_idx_r + 2'd1;
      end
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign io.in_ready  = in_ready_s;
  assign io.out_valid = out_valid_r;
  assign io.out_data  = result_r[BLOCK_W-1 -: WORD_W];
  assign busy         = busy_r;
  assign aes_state    = aes_state_r;
  assign aes_key      = aes_key_r;

endmodule

// File: tb/tb_aes_word_io.sv
// Self-checking bench for aes_word_io with a behavioural AES-128 core model.
module tb_aes_word_io;

  localparam int LATENCY = 21;

  logic clk;
  logic rst = 1'b1;
  logic busy;
  logic [127:0] dut_state;
  logic [127:0] dut_key;
  logic [127:0] core_out;

  aes_word_io_if io ();

  aes_word_io #(.LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (io),
    .busy      (busy),
    .aes_state (dut_state),
    .aes_key   (dut_key),
    .aes_out   (core_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   b [16];
    logic [7:0]   n [16];
    logic [127:0] st;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sbox[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) n[4*c+j] = b[4*((c+j)%4)+j];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
          n[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          n[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          n[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          n[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = n[i];
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  // Core model: output becomes valid LATENCY-1 edges after the inputs settle,
  // so a capture on edge T+LATENCY is the first one that sees the right value.
  logic [127:0] pipe [LATENCY-1];
  always @(posedge clk) begin
    pipe[0] <= aes_enc(dut_state, dut_key);
    for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LATENCY-2];

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  int unsigned lat_q [$];
  logic [31:0] key_words [$];
  logic [31:0] pt_words [$];
  logic [127:0] committed_key = '0;
  bit          in_flight = 1'b0;
  bit          launch_pending = 1'b0;
  int          mon_idx = 0;
  int          ready_mode = 0;
  logic [31:0] last4 [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Block-level model: four key words replace the key, four plaintext words launch a block.
  task automatic model_accept(input logic sel, input logic [31:0] d);
    logic [127:0] ct;
    if (sel) begin
      key_words.push_back(d);
      if (key_words.size() == 4) begin
        committed_key = {key_words[0], key_words[1], key_words[2], key_words[3]};
        key_words.delete();
      end
    end else begin
      pt_words.push_back(d);
      if (pt_words.size() == 4) begin
        ct = aes_enc({pt_words[0], pt_words[1], pt_words[2], pt_words[3]}, committed_key);
        for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
        lat_q.push_back(cyc + 1);
        launch_pending = 1'b1;
        pt_words.delete();
      end
    end
  endtask

  task automatic model_reset();
    key_words.delete();
    pt_words.delete();
    exp_q.delete();
    lat_q.delete();
    committed_key  = '0;
    in_flight      = 1'b0;
    launch_pending = 1'b0;
    mon_idx        = 0;
  endtask

  // Present one word after 'gap' idle cycles; in_valid is left high afterwards.
  task automatic send_word(input logic sel, input logic [31:0] data, input int gap);
    bit done;
    done = 1'b0;
    if (gap > 0) begin
      io.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    io.in_valid = 1'b1;
    io.in_sel   = sel;
    io.in_data  = data;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (io.in_ready) begin
        model_accept(sel, data);
        @(posedge clk);
        #1;
        if (launch_pending) begin
          in_flight      = 1'b1;
          launch_pending = 1'b0;
        end
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail_now("send_word");
      io.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    io.in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!in_flight && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic check_fips(input string tag);
    chk({tag, "_w0"}, 128'(last4[0]), 128'(32'h69c4e0d8));
    chk({tag, "_w1"}, 128'(last4[1]), 128'(32'h6a7b0430));
    chk({tag, "_w2"}, 128'(last4[2]), 128'(32'hd8cdb780));
    chk({tag, "_w3"}, 128'(last4[3]), 128'(32'h70b4c55a));
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       io.out_ready = 1'b1;
        1:       io.out_ready = 1'($urandom_range(0, 1));
        default: io.out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic        prev_ov;
    logic        prev_rdy;
    logic [31:0] prev_data;
    logic [31:0] e;
    int unsigned t;
    prev_ov = 1'b0; prev_rdy = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov  = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        chk("in_ready", 128'(io.in_ready), 128'(!in_flight));
        chk("busy", 128'(busy), 128'(in_flight));
        if (io.out_valid && !prev_ov) begin
          if (lat_q.size() == 0) begin
            fail_now("unexpected_out_valid");
          end else begin
            t = lat_q.pop_front();
            chk("latency", 128'(cyc), 128'(t + LATENCY));
          end
        end
        if (prev_ov && !prev_rdy && io.out_valid)
          chk("stall_hold", 128'(io.out_data), 128'(prev_data));
        if (io.out_valid && io.out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("extra_out_word");
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 128'(io.out_data), 128'(e));
            last4[0] = last4[1]; last4[1] = last4[2]; last4[2] = last4[3];
            last4[3] = io.out_data;
            mon_idx++;
            if (mon_idx == 4) begin
              mon_idx   = 0;
              in_flight = 1'b0;
            end
          end
        end
        prev_ov   = io.out_valid;
        prev_rdy  = io.out_ready;
        prev_data = io.out_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] kw [4];
  logic [31:0] pw [4];

  initial begin : stim
    bit seen;
    io.in_valid = 1'b0;
    io.in_sel   = 1'b0;
    io.in_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", dut_state, 128'h0);
    chk("rst_key", dut_key, 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_out_valid", 128'(io.out_valid), 128'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(io.in_ready), 128'h1);
    chk("post_rst_out_valid", 128'(io.out_valid), 128'h0);
    @(posedge clk);
    #1;

    // FIPS-197 vector
    send_word(1'b1, 32'h00010203, 0);
    send_word(1'b1, 32'h04050607, 1);
    send_word(1'b1, 32'h08090a0b, 0);
    send_word(1'b1, 32'h0c0d0e0f, 2);
    send_word(1'b0, 32'h00112233, 0);
    send_word(1'b0, 32'h44556677, 1);
    send_word(1'b0, 32'h8899aabb, 0);
    send_word(1'b0, 32'hccddeeff, 0);
    wait_idle();
    check_fips("fips");

    // Partial key then same plaintext, with output back-pressure
    send_word(1'b1, $urandom(), 1);
    send_word(1'b1, $urandom(), 0);
    ready_mode = 2;
    send_word(1'b0, 32'h00112233, 0);
    send_word(1'b0, 32'h44556677, 0);
    send_word(1'b0, 32'h8899aabb, 2);
    send_word(1'b0, 32'hccddeeff, 0);
    io.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (io.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("wait_out_valid");
    repeat (10) @(negedge clk);
    chk("stalled_data", 128'(io.out_data), 128'(32'h69c4e0d8));
    chk("stalled_valid", 128'(io.out_valid), 128'h1);
    ready_mode = 1;
    wait_idle();
    check_fips("reuse");

    // Reset five cycles into RUN
    ready_mode = 0;
    for (int i = 0; i < 4; i++) send_word(1'b0, $urandom(), 0);
    io.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrun_state", dut_state, 128'h0);
    chk("midrun_key", dut_key, 128'h0);
    chk("midrun_busy", 128'(busy), 128'h0);
    chk("midrun_out_valid", 128'(io.out_valid), 128'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_in_ready", 128'(io.in_ready), 128'h1);
    repeat (LATENCY + 8) @(posedge clk);
    #1;

    // Interleaving: K0 P0 K1 P1 K2 P2 P3 launches with the old (reset) key,
    // K3 is held off until LOAD and then completes the new key.
    ready_mode = 1;
    for (int i = 0; i < 4; i++) begin
      kw[i] = $urandom();
      pw[i] = $urandom();
    end
    send_word(1'b1, kw[0], 0);
    send_word(1'b0, pw[0], 1);
    send_word(1'b1, kw[1], 0);
    send_word(1'b0, pw[1], 0);
    send_word(1'b1, kw[2], 2);
    send_word(1'b0, pw[2], 0);
    send_word(1'b0, pw[3], 0);
    send_word(1'b1, kw[3], 0);
    for (int i = 0; i < 4; i++) send_word(1'b0, pw[i], 0);
    wait_idle();
    chk("interleave_key", dut_key, {kw[0], kw[1], kw[2], kw[3]});

    // Randomised blocks with mixed key traffic and gaps
    for (int it = 0; it < 6; it++) begin
      int nk;
      int np;
      nk = $urandom_range(0, 5);
      np = 4;
      ready_mode = $urandom_range(0, 1);
      while (np + nk > 0) begin
        logic s;
        if (nk > 0 && (np == 0 || $urandom_range(0, 1) == 1)) begin
          s = 1'b1;
          nk--;
        end else begin
          s = 1'b0;
          np--;
        end
        send_word(s, $urandom(), $urandom_range(0, 2));
      end
    end
    wait_idle();
    chk("queue_drained", 128'(exp_q.size()), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
